// File: rtl/fb_pkg.sv
// Shared types and defaults for the dual-page frame buffer.
//   fb_state_t  : clear-engine FSM state
//   *_DEF       : default geometry / widths (640x480, 4-bit palette index)
//   pix_count() : pixels in one page
package fb_pkg;

  typedef enum logic {FB_IDLE, FB_CLEAR} fb_state_t;

  localparam int unsigned H_RES_DEF  = 640;
  localparam int unsigned V_RES_DEF  = 480;
  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 4;

  function automatic int unsigned pix_count(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, one cycle after raddr_i
module fb_sdp_ram #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned AW     = 20
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dual_page_frame_buffer.sv
// Double-buffered pixel store for the VGA path. Drawing writes the back page,
// the display reads the front page; page swaps are only committed on
// frame_start so a half-drawn frame is never shown. A clear engine can fill
// the back page with CLEAR_VAL, one word per cycle.
//
// Ports:
//   Clk, Reset        : clock, asynchronous active-high reset
//   data_In, we,
//   write_address     : back-page write (dropped while clearing / out of range)
//   read_address      : front-page read address
//   data_Out          : read data, 1-cycle latency, 0 for out-of-range reads
//   frame_start       : start-of-vblank pulse, commits a pending swap
//   swap_req          : request a page swap at the next frame_start
//   clear_req         : start filling the back page with CLEAR_VAL
//   write_ready       : 1 while external writes are accepted
//   swap_pending      : swap requested, not yet committed
//   front_page        : page currently displayed
module dual_page_frame_buffer
  import fb_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       H_RES     = H_RES_DEF,
  parameter int unsigned       V_RES     = V_RES_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] data_In,
  input  logic [ADDR_W-1:0] write_address,
  input  logic              we,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] data_Out,
  input  logic              frame_start,
  input  logic              swap_req,
  input  logic              clear_req,
  output logic              write_ready,
  output logic              swap_pending,
  output logic              front_page
);

  localparam int unsigned       PIX_CNT   = pix_count(H_RES, V_RES);
  // One extra bit so a page that exactly fills the address space still compares correctly.
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W+1)'(PIX_CNT);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(PIX_CNT - 1);

  fb_state_t         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              write_ready_q;
  logic              front_q, front_d;
  logic              pending_q, pending_d;
  logic              rd_valid_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              clearing;
  logic              ext_wr;
  logic              commit;

  logic              ram_we;
  logic [ADDR_W:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W:0]   ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_in_range = {1'b0, write_address} < PIX_LIMIT;
  assign rd_in_range = {1'b0, read_address} < PIX_LIMIT;
  assign clearing    = (state_q == FB_CLEAR);
  assign ext_wr      = we && write_ready_q && wr_in_range;

  // Clear engine owns the write port while active; both always target the back page.
  assign ram_we    = clearing || ext_wr;
  assign ram_waddr = {~front_q, (clearing ? clr_cnt_q : write_address)};
  assign ram_wdata = clearing ? CLEAR_VAL : data_In;
  assign ram_raddr = {front_q, read_address};

  fb_sdp_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= FB_IDLE;
      clr_cnt_q     <= '0;
      write_ready_q <= 1'b1;
    end else begin
      case (state_q)
        FB_IDLE: begin
          if (clear_req) begin
            state_q       <= FB_CLEAR;
            clr_cnt_q     <= '0;
            write_ready_q <= 1'b0;
          end
        end
        FB_CLEAR: begin
          if (clr_cnt_q == LAST_PIX) begin
            state_q       <= FB_IDLE;
            clr_cnt_q     <= '0;
            write_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q       <= FB_IDLE;
          write_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Swap commits only when idle so a clear never lands on the displayed page.
  // A swap_req coinciding with a commit re-arms the request rather than being lost.
  assign commit = frame_start && pending_q && !clearing;

  always_comb begin
    front_d   = front_q ^ commit;
    pending_d = (pending_q && !commit) || swap_req;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      front_q    <= front_d;
      pending_q  <= pending_d;
      rd_valid_q <= rd_in_range;
    end
  end

  // RAM read register has no reset; the valid flag forces 0 after reset and for out-of-range reads.
  assign data_Out     = rd_valid_q ? ram_rdata : '0;
  assign write_ready  = write_ready_q;
  assign swap_pending = pending_q;
  assign front_page   = front_q;

endmodule

// File: tb/tb_dual_page_frame_buffer.sv
module tb_dual_page_frame_buffer;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int PIX = H * V;
  localparam int AW  = 6;
  localparam int DW  = 4;
  localparam int CLR = 0;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] data_In;
  logic [AW-1:0] write_address;
  logic          we;
  logic [AW-1:0] read_address;
  logic [DW-1:0] data_Out;
  logic          frame_start;
  logic          swap_req;
  logic          clear_req;
  logic          write_ready;
  logic          swap_pending;
  logic          front_page;

  dual_page_frame_buffer #(
    .DATA_W    (DW),
    .H_RES     (H),
    .V_RES     (V),
    .ADDR_W    (AW),
    .CLEAR_VAL (DW'(CLR))
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .data_In       (data_In),
    .write_address (write_address),
    .we            (we),
    .read_address  (read_address),
    .data_Out      (data_Out),
    .frame_start   (frame_start),
    .swap_req      (swap_req),
    .clear_req     (clear_req),
    .write_ready   (write_ready),
    .swap_pending  (swap_pending),
    .front_page    (front_page)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: two pages of words (-1 = never written), displayed page,
  // pending flag, and how many words the clear engine still has to write.
  int mem_m [2][PIX];
  int front_m;
  int pending_m;
  int clear_left;
  int exp_dout;

  typedef struct {
    logic we;
    int   wa;
    int   din;
    int   ra;
    logic fs;
    logic sw;
    logic clr;
    int   exp_dout;
    int   exp_fp;
    int   exp_sp;
    int   exp_wr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pat(input int a);
    return (a % 15) + 1;
  endfunction

  task automatic model_reset();
    front_m    = 0;
    pending_m  = 0;
    clear_left = 0;
    exp_dout   = 0;
  endtask

  // Applies the rules to the inputs that were present at the edge just taken.
  task automatic model_step();
    int     ra, wa, nd, back;
    logic   busy, cm;
    ra   = int'(read_address);
    wa   = int'(write_address);
    back = 1 - front_m;
    busy = (clear_left > 0);
    nd   = (ra < PIX) ? mem_m[front_m][ra] : 0;
    if (busy) begin
      mem_m[back][PIX - clear_left] = CLR;
      clear_left--;
    end else begin
      if (we && wa < PIX) mem_m[back][wa] = int'(data_In);
      if (clear_req) clear_left = PIX;
    end
    cm = frame_start && (pending_m != 0) && !busy;
    pending_m = ((pending_m != 0) && !cm) || swap_req ? 1 : 0;
    if (cm) front_m = 1 - front_m;
    exp_dout = nd;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    chk("write_ready", int'(write_ready), (clear_left == 0) ? 1 : 0);
    chk("swap_pending", int'(swap_pending), pending_m);
    chk("front_page", int'(front_page), front_m);
    if (exp_dout >= 0) chk("data_out", int'(data_Out), exp_dout);
  endtask

  task automatic idle_inputs();
    we = 1'b0; write_address = '0; data_In = '0; read_address = '0;
    frame_start = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < PIX; a++) mem_m[p][a] = -1;

    //                we  wa  din ra  fs  sw  clr dout fp sp wr
    vecs[0]  = '{1'b1, 5, 10, 0, 1'b0, 1'b0, 1'b0, -1, 0, 0, 1};
    vecs[1]  = '{1'b1, 2,  7, 0, 1'b0, 1'b1, 1'b0, -1, 0, 1, 1};
    vecs[2]  = '{1'b0, 0,  0, 0, 1'b1, 1'b0, 1'b0, -1, 1, 0, 1};
    vecs[3]  = '{1'b0, 0,  0, 5, 1'b0, 1'b0, 1'b0, 10, 1, 0, 1};
    vecs[4]  = '{1'b1, 2,  3, 2, 1'b0, 1'b0, 1'b0,  7, 1, 0, 1};
    vecs[5]  = '{1'b0, 0,  0, 2, 1'b0, 1'b0, 1'b0,  7, 1, 0, 1};
    vecs[6]  = '{1'b1, 32, 15, 32, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1};
    vecs[7]  = '{1'b0, 0,  0, 2, 1'b0, 1'b0, 1'b0,  7, 1, 0, 1};
    vecs[8]  = '{1'b0, 0,  0, 5, 1'b1, 1'b1, 1'b0, 10, 1, 1, 1};
    vecs[9]  = '{1'b0, 0,  0, 5, 1'b1, 1'b0, 1'b0, 10, 0, 0, 1};
    vecs[10] = '{1'b0, 0,  0, 2, 1'b0, 1'b0, 1'b0,  3, 0, 0, 1};
    vecs[11] = '{1'b0, 0,  0, 2, 1'b0, 1'b1, 1'b0,  3, 0, 1, 1};
    vecs[12] = '{1'b0, 0,  0, 2, 1'b0, 1'b1, 1'b0,  3, 0, 1, 1};
    vecs[13] = '{1'b0, 0,  0, 2, 1'b1, 1'b0, 1'b0,  3, 1, 0, 1};
    vecs[14] = '{1'b0, 0,  0, 2, 1'b0, 1'b0, 1'b0,  7, 1, 0, 1};

    // Reset
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_data_out", int'(data_Out), 0);
    chk("rst_front_page", int'(front_page), 0);
    chk("rst_swap_pending", int'(swap_pending), 0);
    chk("rst_write_ready", int'(write_ready), 1);
    model_reset();
    Reset = 1'b0;

    // Directed table: write/swap/read, back-page isolation, out-of-range, toggle edge
    foreach (vecs[i]) begin
      we = vecs[i].we; write_address = AW'(vecs[i].wa); data_In = DW'(vecs[i].din);
      read_address = AW'(vecs[i].ra); frame_start = vecs[i].fs;
      swap_req = vecs[i].sw; clear_req = vecs[i].clr;
      cycle();
      chk($sformatf("vec%0d_front_page", i), int'(front_page), vecs[i].exp_fp);
      chk($sformatf("vec%0d_swap_pending", i), int'(swap_pending), vecs[i].exp_sp);
      chk($sformatf("vec%0d_write_ready", i), int'(write_ready), vecs[i].exp_wr);
      if (vecs[i].exp_dout >= 0)
        chk($sformatf("vec%0d_data_out", i), int'(data_Out), vecs[i].exp_dout);
    end
    idle_inputs();

    // Clear of back page 0 with writes, swap_req and frame_start arriving mid-clear
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    low_cnt = (write_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      we = 1'b1; write_address = AW'(3); data_In = DW'(5);
      swap_req = (i == 3); frame_start = (i == 10);
      cycle();
      if (i == 10) begin
        chk("clr_front_hold", int'(front_page), 1);
        chk("clr_swap_pending", int'(swap_pending), 1);
      end
      if (write_ready == 1'b0) low_cnt++;
      else break;
    end
    idle_inputs();
    chk("clr_low_cycles", low_cnt, PIX);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("clr_swap_commit_fp", int'(front_page), 0);
    chk("clr_swap_commit_sp", int'(swap_pending), 0);
    for (int a = 0; a < PIX; a++) begin
      read_address = AW'(a);
      cycle();
      chk($sformatf("clr_word%0d", a), int'(data_Out), CLR);
    end
    idle_inputs();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      we            = ($urandom_range(0, 3) != 0);
      write_address = AW'($urandom_range(0, PIX + 3));
      data_In       = DW'($urandom);
      read_address  = AW'($urandom_range(0, PIX + 3));
      frame_start   = ($urandom_range(0, 7) == 0);
      swap_req      = ($urandom_range(0, 7) == 0);
      clear_req     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();

    // Reset in the middle of a clear of page 1
    for (int i = 0; i < 40; i++) begin
      if (clear_left == 0) break;
      cycle();
    end
    if (front_m == 1) begin
      swap_req = 1'b1; cycle(); swap_req = 1'b0;
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
    end
    for (int a = 0; a < PIX; a++) begin
      we = 1'b1; write_address = AW'(a); data_In = DW'(pat(a));
      cycle();
    end
    we = 1'b0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (10) cycle();
    Reset = 1'b1;
    #1;
    chk("arst_data_out", int'(data_Out), 0);
    chk("arst_front_page", int'(front_page), 0);
    chk("arst_write_ready", int'(write_ready), 1);
    chk("arst_swap_pending", int'(swap_pending), 0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    chk("arst_swap_fp", int'(front_page), 1);
    for (int a = 0; a < PIX; a++) begin
      read_address = AW'(a);
      cycle();
      chk($sformatf("arst_word%0d", a), int'(data_Out), (a < 10) ? CLR : pat(a));
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
